keypad_entry_ctrl: RTL and testbench
====================================

KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 4: maximum digits held in one entry (1..4).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 500000000: idle cycles in ENTRY before auto-clear (5 s at 100 MHz).
REQ-003 SHALL have port clk_in  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port key_hex  input  4  hex code of the currently pressed key, from the keyboard interface.
REQ-006 SHALL have port key_pressed  input  1  debounced key-down level from the keyboard interface.
REQ-007 SHALL have port entry_value  output  16  live entry, newest digit in [3:0], for display.
REQ-008 SHALL have port entry_count  output  3  number of digits currently entered (0..MAX_DIGITS).
REQ-009 SHALL have port entry_active  output  1  high while in state ENTRY.
REQ-010 SHALL have port out_value  output  16  committed entry value.
REQ-011 SHALL have port out_digits  output  3  digit count of committed value.
REQ-012 SHALL have port out_valid  output  1  committed value available.
REQ-013 SHALL have port out_ready  input  1  consumer accepts committed value.
REQ-014 SHALL have port digit_overflow  output  1  one-cycle pulse: digit rejected, entry full.
REQ-015 SHALL have port entry_timeout  output  1  one-cycle pulse: entry cleared by timeout.

Function
REQ-016 SHALL generate a key event in cycle n when key_pressed=1 and its registered copy key_q=0; key_hex sampled in that same cycle; exactly one event per press regardless of hold time.
REQ-017 SHALL decode events: 0x0-0x9 DIGIT, 0xA ENTER, 0xB BACKSPACE, 0xC CLEAR, 0xD-0xF ignored (no state or output change).
REQ-018 SHALL implement states IDLE (count 0), ENTRY (count >= 1), HOLD (out_valid asserted).
REQ-019 SHALL, on DIGIT in IDLE/ENTRY with count < MAX_DIGITS, set entry_value = {entry_value[11:0], key_hex}, count+1, state ENTRY; visible cycle n+1.
REQ-020 SHALL, on DIGIT with count == MAX_DIGITS, leave entry unchanged and pulse digit_overflow in cycle n+1.
REQ-021 SHALL, on BACKSPACE with count > 0, set entry_value = entry_value >> 4, count-1; go IDLE when count reaches 0; ignore BACKSPACE at count 0.
REQ-022 SHALL, on CLEAR, zero entry_value and count, go IDLE.
REQ-023 SHALL, on ENTER with count > 0, load out_value=entry_value, out_digits=count, set out_valid=1, zero entry, go HOLD, all in cycle n+1; ignore ENTER at count 0.
REQ-024 SHALL, in HOLD, keep out_value/out_digits stable and drop all key events.
REQ-025 SHALL complete transfer in the cycle out_valid=1 and out_ready=1: out_valid=0 and state IDLE next cycle; out_ready while out_valid=0 has no effect.
REQ-026 SHALL run a 32-bit idle counter in ENTRY only, cleared on every decoded (non-ignored) event and on leaving ENTRY.
REQ-027 SHALL, when the idle counter reaches TIMEOUT_CYCLES-1 in ENTRY with no event that cycle, zero entry, go IDLE, pulse entry_timeout next cycle.
REQ-028 SHALL give a key event priority over timeout in the same cycle (event processed, counter restarts).

Reset
REQ-029 SHALL, while reset=0, force state IDLE, entry_value=0, entry_count=0, entry_active=0, out_value=0, out_digits=0, out_valid=0, digit_overflow=0, entry_timeout=0, idle counter=0, key_q=1.
REQ-030 SHALL, with key_q reset to 1, ignore a key held across reset release until it is released and pressed again.
REQ-031 SHALL abandon any entry or pending out_valid on reset assertion mid-operation, no commit.

Verification
REQ-032 Press 1,2,3, ENTER (0xA), out_ready=1 -> out_value=0x0123, out_digits=3, out_valid high one cycle, then IDLE.
REQ-033 Press 9,8,7,6,5 with MAX_DIGITS=4 -> entry_value=0x9876, count=4, one digit_overflow pulse on '5'.
REQ-034 Press 4,5, BACKSPACE, BACKSPACE, ENTER -> entry_value 0x0045 -> 0x0004 -> 0x0000, IDLE, no out_valid.
REQ-035 Commit 0x0007, out_ready=0 for 20 cycles, press 3 meanwhile -> out_value stays 0x0007, entry unchanged; out_ready=1 -> out_valid drops next cycle.
REQ-036 TIMEOUT_CYCLES=16, press 2, no further keys -> entry_timeout pulse 16 cycles after event, entry_value=0, IDLE.
REQ-037 Hold key 5 across reset release -> no event until release and re-press; reset=0 mid-entry -> all outputs zero immediately.

Source files
------------

// File: rtl/keypad_entry_ctrl.sv
// rtl/keypad_entry_ctrl.sv - hex keypad digit entry with backspace/clear, commit handshake and idle timeout
module keypad_entry_ctrl #(
    parameter int MAX_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [3:0]  key_hex,
    input  logic        key_pressed,
    output logic [15:0] entry_value,
    output logic [2:0]  entry_count,
    output logic        entry_active,
    output logic [15:0] out_value,
    output logic [2:0]  out_digits,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        digit_overflow,
    output logic        entry_timeout
);

    typedef enum logic [1:0] {IDLE, ENTRY, HOLD} state_t;

    localparam logic [2:0]  MAX_CNT      = 3'(MAX_DIGITS);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;

    state_t      state;
    logic        key_q;
    logic [31:0] idle_cnt;
    logic        key_event;
    logic        is_digit;

    assign key_event    = key_pressed & ~key_q;
    assign is_digit     = (key_hex <= 4'h9);
    assign entry_active = (state == ENTRY);

    // key_q resets high so a key held through reset release needs a fresh press
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            key_q          <= 1'b1;
            idle_cnt       <= 32'd0;
            entry_value    <= 16'd0;
            entry_count    <= 3'd0;
            out_value      <= 16'd0;
            out_digits     <= 3'd0;
            out_valid      <= 1'b0;
            digit_overflow <= 1'b0;
            entry_timeout  <= 1'b0;
        end else begin
            key_q          <= key_pressed;
            digit_overflow <= 1'b0;
            entry_timeout  <= 1'b0;
            case (state)
                IDLE, ENTRY: begin
                    if (key_event && is_digit) begin
                        idle_cnt <= 32'd0;
                        if (entry_count < MAX_CNT) begin
                            entry_value <= {entry_value[11:0], key_hex};
                            entry_count <= entry_count + 3'd1;
                            state       <= ENTRY;
                        end else begin
                            digit_overflow <= 1'b1;
                        end
                    end else if (key_event && key_hex == KEY_BACK) begin
                        idle_cnt <= 32'd0;
                        if (entry_count != 3'd0) begin
                            entry_value <= entry_value >> 4;
                            entry_count <= entry_count - 3'd1;
                            if (entry_count == 3'd1)
                                state <= IDLE;
                        end
                    end else if (key_event && key_hex == KEY_CLEAR) begin
                        idle_cnt    <= 32'd0;
                        entry_value <= 16'd0;
                        entry_count <= 3'd0;
                        state       <= IDLE;
                    end else if (key_event && key_hex == KEY_ENTER) begin
                        idle_cnt <= 32'd0;
                        if (entry_count != 3'd0) begin
                            out_value   <= entry_value;
                            out_digits  <= entry_count;
                            out_valid   <= 1'b1;
                            entry_value <= 16'd0;
                            entry_count <= 3'd0;
                            state       <= HOLD;
                        end
                    end else if (state == ENTRY) begin
                        // codes 0xD-0xF fall through here and do not restart the idle count
                        if (idle_cnt == TIMEOUT_LAST) begin
                            idle_cnt      <= 32'd0;
                            entry_value   <= 16'd0;
                            entry_count   <= 3'd0;
                            entry_timeout <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            idle_cnt <= idle_cnt + 32'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb/tb_keypad_entry_ctrl.sv - directed self-checking bench for keypad_entry_ctrl
module tb_keypad_entry_ctrl;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [3:0]  key_hex;
    logic        key_pressed;
    logic [15:0] entry_value;
    logic [2:0]  entry_count;
    logic        entry_active;
    logic [15:0] out_value;
    logic [2:0]  out_digits;
    logic        out_valid;
    logic        out_ready;
    logic        digit_overflow;
    logic        entry_timeout;

    int n_cmp = 0;
    int n_bad = 0;
    logic mid_ovf;
    logic mid_valid;

    keypad_entry_ctrl #(.MAX_DIGITS(4), .TIMEOUT_CYCLES(16)) dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .key_hex       (key_hex),
        .key_pressed   (key_pressed),
        .entry_value   (entry_value),
        .entry_count   (entry_count),
        .entry_active  (entry_active),
        .out_value     (out_value),
        .out_digits    (out_digits),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .digit_overflow(digit_overflow),
        .entry_timeout (entry_timeout)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // key held for one cycle; single-cycle pulses are captured in the cycle after the event
    task automatic press(input logic [3:0] k);
        @(negedge clk_in);
        key_hex     = k;
        key_pressed = 1'b1;
        @(negedge clk_in);
        mid_ovf     = digit_overflow;
        mid_valid   = out_valid;
        key_pressed = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_in);
    endtask

    initial begin
        reset       = 1'b0;
        key_hex     = 4'h5;
        key_pressed = 1'b1;
        out_ready   = 1'b0;
        cycles(3);
        check("rst_entry_value", 32'(entry_value), 32'h0);
        check("rst_entry_count", 32'(entry_count), 32'h0);
        check("rst_active", 32'(entry_active), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_value", 32'(out_value), 32'h0);
        check("rst_pulses", 32'({digit_overflow, entry_timeout}), 32'h0);

        // key 5 held across reset release must not register
        reset = 1'b1;
        cycles(4);
        check("held_no_event", 32'(entry_count), 32'h0);
        key_pressed = 1'b0;
        cycles(2);
        check("release_no_event", 32'(entry_count), 32'h0);
        press(4'h5);
        check("repress_value", 32'(entry_value), 32'h5);
        check("repress_count", 32'(entry_count), 32'h1);
        press(4'hC);
        check("clear_value", 32'(entry_value), 32'h0);
        check("clear_active", 32'(entry_active), 32'h0);

        // 1,2,3 ENTER with consumer ready
        out_ready = 1'b1;
        press(4'h1);
        press(4'h2);
        press(4'h3);
        check("e123_value", 32'(entry_value), 32'h0123);
        check("e123_count", 32'(entry_count), 32'h3);
        check("e123_active", 32'(entry_active), 32'h1);
        press(4'hA);
        check("commit_valid_pulse", 32'(mid_valid), 32'h1);
        check("commit_value", 32'(out_value), 32'h0123);
        check("commit_digits", 32'(out_digits), 32'h3);
        check("commit_valid_drop", 32'(out_valid), 32'h0);
        check("commit_idle", 32'(entry_active), 32'h0);
        check("commit_entry_zero", 32'(entry_value), 32'h0);
        out_ready = 1'b0;

        // 9,8,7,6 fill the entry, 5 overflows
        press(4'h9);
        press(4'h8);
        press(4'h7);
        press(4'h6);
        check("fill_no_ovf", 32'(mid_ovf), 32'h0);
        press(4'h5);
        check("ovf_pulse", 32'(mid_ovf), 32'h1);
        check("ovf_pulse_end", 32'(digit_overflow), 32'h0);
        check("ovf_value", 32'(entry_value), 32'h9876);
        check("ovf_count", 32'(entry_count), 32'h4);
        press(4'hE);
        check("ignored_key", 32'(entry_value), 32'h9876);
        press(4'hC);

        // 4,5 BACKSPACE BACKSPACE ENTER
        press(4'h4);
        press(4'h5);
        check("bs_start", 32'(entry_value), 32'h0045);
        press(4'hB);
        check("bs1_value", 32'(entry_value), 32'h0004);
        check("bs1_count", 32'(entry_count), 32'h1);
        press(4'hB);
        check("bs2_value", 32'(entry_value), 32'h0);
        check("bs2_idle", 32'(entry_active), 32'h0);
        press(4'hB);
        check("bs_at_zero", 32'(entry_count), 32'h0);
        press(4'hA);
        check("enter_empty", 32'({mid_valid, out_valid}), 32'h0);

        // commit 7, consumer stalls while another key arrives
        press(4'h7);
        press(4'hA);
        check("hold_valid", 32'(out_valid), 32'h1);
        check("hold_value", 32'(out_value), 32'h0007);
        check("hold_digits", 32'(out_digits), 32'h1);
        cycles(8);
        press(4'h3);
        cycles(8);
        check("hold_drop_key", 32'(entry_count), 32'h0);
        check("hold_value_stable", 32'(out_value), 32'h0007);
        check("hold_still_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        @(negedge clk_in);
        check("hold_release", 32'(out_valid), 32'h0);
        check("hold_release_idle", 32'(entry_active), 32'h0);
        out_ready = 1'b0;

        // timeout: event edge, then 16 edges later the pulse is set
        press(4'h2);
        check("to_entry", 32'(entry_value), 32'h2);
        for (int i = 3; i <= 16; i++) begin
            @(negedge clk_in);
            check("to_not_early", 32'(entry_timeout), 32'h0);
        end
        @(negedge clk_in);
        check("to_pulse", 32'(entry_timeout), 32'h1);
        check("to_value", 32'(entry_value), 32'h0);
        check("to_idle", 32'(entry_active), 32'h0);
        @(negedge clk_in);
        check("to_pulse_end", 32'(entry_timeout), 32'h0);

        // reset mid-entry and with a pending commit
        press(4'h8);
        reset = 1'b0;
        #1;
        check("midrst_value", 32'(entry_value), 32'h0);
        check("midrst_count", 32'(entry_count), 32'h0);
        @(negedge clk_in);
        reset = 1'b1;
        press(4'h6);
        press(4'hA);
        check("pre_rst_valid", 32'(out_valid), 32'h1);
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_out_value", 32'(out_value), 32'h0);
        @(negedge clk_in);
        reset = 1'b1;
        cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
